// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, data width and baud divisor helper
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser plus delay flop for falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_s,
  output logic fall_edge
);
  logic s1, s2, d;
  // idle-high reset so a line held low at reset release still looks like an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, d} <= 3'b111;
    else {s1, s2, d} <= {rxd, s1, s2};
  assign rx_s = s2;
  assign fall_edge = d & ~s2;
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with valid/ready holding register and error pulses
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   uart_rxd,
  input  logic                   rx_ready,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] HALF = 16'(BPS_CNT / 2 - 1);
  localparam logic [15:0] FULL = 16'(BPS_CNT - 1);
  state_t state;
  logic [15:0] clk_cnt;
  logic [3:0] bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic dlv, rx_s, fall_edge;
  uart_rx_sync u_sync (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .rxd(uart_rxd),
    .rx_s(rx_s),
    .fall_edge(fall_edge)
  );
  // frame FSM: validate start at mid-bit, sample data and stop at bit centres
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_busy <= 1'b0;
      dlv <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dlv <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (fall_edge) begin
            state <= START;
            clk_cnt <= '0;
            rx_busy <= 1'b1;
          end
        START:
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state <= rx_s ? IDLE : DATA;
            rx_busy <= ~rx_s;
          end else clk_cnt <= clk_cnt + 16'd1;
        DATA:
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(UART_DATA_W - 1)) state <= STOP;
          end else clk_cnt <= clk_cnt + 16'd1;
        STOP:
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            state <= IDLE;
            rx_busy <= 1'b0;
            dlv <= rx_s;
            frame_err <= ~rx_s;
          end else clk_cnt <= clk_cnt + 16'd1;
      endcase
    end
  // holding register: load when empty or being drained, otherwise flag overrun
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dlv) begin
        if (!rx_valid || rx_ready) begin
          rx_data <= shreg;
          rx_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: randomized bit-level stimulus against a frame-level byte/flag model
module tb_uart_recv;
  localparam int BPS = 434;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_err, overrun;
  int checks = 0, failures = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, busy_cycles = 0, hold_viol = 0, same_viol = 0;
  int first_valid_cyc = -1, t_start = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_recv dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_rxd(uart_rxd),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk)
    if (sys_rst_n) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid && !pv && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) same_viol++;
      if (pv && !pr && rx_valid && rx_data !== pd) hold_viol++;
      if (rx_busy) busy_cycles++;
      pv = rx_valid;
      pr = rx_ready;
      pd = rx_data;
    end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_mon();
    got.delete();
    exp_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    busy_cycles = 0;
    first_valid_cyc = -1;
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    wait_cycles(BPS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic check_queue(input string name);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s count got=%0d exp=%0d", name, got.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s byte%0d got=%h exp=%h", name, i, got[i], exp_q[i]);
        end
      end
  endtask

  task automatic test_reset();
    wait_cycles(5);
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {rx_data, rx_valid, rx_busy, frame_err, overrun});
    end
    sys_rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_cycles(20);
    check_queue("single");
    checks++;
    if (first_valid_cyc - t_start < 4124 || first_valid_cyc - t_start > 4128) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=4126+/-2", first_valid_cyc - t_start);
    end
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_flags fe=%0d ov=%0d valid=%b exp=0/0/0", fe_cnt, ov_cnt, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v[3];
    v = '{8'h00, 8'hFF, 8'h55};
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_frame(v[i], 1'b1);
      exp_q.push_back(v[i]);
    end
    wait_cycles(20);
    check_queue("back_to_back");
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL b2b_flags fe=%0d ov=%0d exp=0/0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    uart_rxd = 1'b0;
    wait_cycles(100);
    uart_rxd = 1'b1;
    wait_cycles(400);
    checks++;
    if (busy_cycles < 214 || busy_cycles > 220) begin
      failures++;
      $display("FAIL glitch_busy got=%0d exp=217+/-3", busy_cycles);
    end
    checks++;
    if (got.size() != 0 || fe_cnt != 0 || ov_cnt != 0 || rx_busy !== 1'b0 || first_valid_cyc >= 0) begin
      failures++;
      $display("FAIL glitch_quiet bytes=%0d fe=%0d ov=%0d busy=%b exp=0/0/0/0", got.size(), fe_cnt, ov_cnt, rx_busy);
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    wait_cycles(20);
    checks++;
    if (fe_cnt != 1 || first_valid_cyc >= 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL frame_err fe=%0d valid_seen=%0d ov=%0d exp=1/0/0", fe_cnt, first_valid_cyc >= 0, ov_cnt);
    end
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    wait_cycles(20);
    check_queue("after_frame_err");
  endtask

  task automatic test_overrun();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(20);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      failures++;
      $display("FAIL overrun_hold valid=%b data=%h exp=1/11", rx_valid, rx_data);
    end
    checks++;
    if (ov_cnt != 1 || fe_cnt != 0) begin
      failures++;
      $display("FAIL overrun_pulse ov=%0d fe=%0d exp=1/0", ov_cnt, fe_cnt);
    end
    checks++;
    if (hold_viol != 0) begin
      failures++;
      $display("FAIL overrun_stable changes=%0d exp=0", hold_viol);
    end
    rx_ready = 1'b1;
    wait_cycles(5);
    exp_q.push_back(8'h11);
    check_queue("overrun_drain");
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drop valid=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h5A;
    rx_ready = 1'b0;
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    wait_cycles(20);
    checks++;
    if (rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre valid=%b exp=1", rx_valid);
    end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    uart_rxd = b[4];
    wait_cycles(200);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h exp=000", {rx_data, rx_valid, rx_busy, frame_err, overrun});
    end
    wait_cycles(3);
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    sys_rst_n = 1'b1;
    wait_cycles(10);
    clear_mon();
    send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    wait_cycles(20);
    check_queue("after_reset_mid");
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL reset_mid_flags fe=%0d ov=%0d exp=0/0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_random();
    int exp_fe;
    logic [7:0] b;
    logic stop;
    clear_mon();
    exp_fe = 0;
    same_viol = 0;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) exp_q.push_back(b);
      else exp_fe++;
      wait_cycles(stop ? $urandom_range(0, 3) : $urandom_range(1, 4));
    end
    wait_cycles(20);
    check_queue("random");
    checks++;
    if (fe_cnt != exp_fe || ov_cnt != 0 || same_viol != 0) begin
      failures++;
      $display("FAIL random_flags fe=%0d ov=%0d both=%0d exp=%0d/0/0", fe_cnt, ov_cnt, same_viol, exp_fe);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
